// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO drain stage serializing bytes onto a UART line (start, 8 data LSB first, stop)
// Define FIFO_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DIV_BITS     = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       empty,
   input  logic [7:0] rdata,
   output logic       ren,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

`ifdef FIFO_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [DIV_BITS-1:0] LAST = DIV_BITS'(CLKS_PER_BIT - 1);

   state_t              state_q, state_d;
   logic [DIV_BITS-1:0] cnt_q, cnt_d;
   logic [2:0]          bit_idx_q, bit_idx_d;
   logic [7:0]          shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                bit_end;
`ifdef FIFO_UART_PARITY_EN
   logic                parity_q, parity_d;
`endif

   // Pop only from IDLE so the FIFO never sees a read while empty.
   assign ren     = rst_n && (state_q == IDLE) && !empty;
   assign bit_end = (cnt_q == LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
`ifdef FIFO_UART_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (ren) begin
               shift_d = rdata;
               cnt_d   = '0;
               state_d = START;
`ifdef FIFO_UART_PARITY_EN
               parity_d = ^rdata;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = DATA;
            end else begin
               cnt_d = cnt_q + DIV_BITS'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d     = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + DIV_BITS'(1);
            end
         end
`ifdef FIFO_UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + DIV_BITS'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + DIV_BITS'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so the registered line lines up with the state.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_PARITY_EN
         PARITY:  tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == STOP) && (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= 3'd0;
         shift_q      <= 8'h00;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef FIFO_UART_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef FIFO_UART_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with a small FIFO model
module tb_fifo_uart_tx;
   localparam int C = 4;
`ifdef FIFO_UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold = 1'b1;
   logic       empty, ren, tx, busy, frame_done;
   logic [7:0] rdata;
   logic [7:0] mem [0:31];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         cyc = 0;
   int         viol = 0;
   int         pops[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_bytes [0:19];
   int         next_wr;

   fifo_uart_tx #(.CLKS_PER_BIT(C), .DIV_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .empty(empty), .rdata(rdata),
      .ren(ren), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   assign empty = hold || (wr_ptr == rd_ptr);
   assign rdata = mem[rd_ptr[4:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ren) begin
         rd_ptr <= rd_ptr + 1;
         pops.push_back(cyc);
      end
   end

   always @(negedge clk) if (ren && empty) viol <= viol + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[4:0]] = b;
      wr_ptr++;
   endtask

   task automatic check_frame(input logic [7:0] b, input string tag);
      logic [NB-1:0] bits;
      int n;
      n = 0;
      while (ren !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, " pop"}, {31'd0, ren}, 32'd1);
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = b;
`ifdef FIFO_UART_PARITY_EN
      bits[9] = ^b;
`endif
      @(posedge clk);
      for (int k = 0; k < NB; k++) begin
         for (int c = 0; c < C; c++) begin
            @(negedge clk);
            check($sformatf("%s bit%0d cyc%0d", tag, k, c), {busy, tx, frame_done},
                  {1'b1, bits[k], (k == NB - 1) && (c == C - 1)});
         end
      end
      @(negedge clk);
      check({tag, " idle_after"}, {busy, tx, frame_done}, 3'b010);
   endtask

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      push(8'h11);
      repeat (2) @(negedge clk);
      check("reset", {ren, tx, busy, frame_done}, 4'b0100);
      rd_ptr = 0;
      wr_ptr = 0;
      hold  = 1'b1;
      rst_n = 1'b1;

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("idle", {ren, tx, busy, frame_done}, 4'b0100);
      end
      hold = 1'b0;

      push(8'hA5);
      #1;
      check_frame(8'hA5, "single");
      check("single_pops", pops.size(), 1);
      @(negedge clk);
      check("single_no_ren", {31'd0, ren}, 32'd0);

      push(8'h00);
      push(8'hFF);
      #1;
      check_frame(8'h00, "b2b0");
      check_frame(8'hFF, "b2b1");
      check("b2b_spacing", pops[2] - pops[1], NB * C + 1);
      check("b2b_drained", {ren, empty}, 2'b01);

      push(8'h07);
      push(8'hA5);
      #1;
      check_frame(8'h07, "par07");
      check_frame(8'hA5, "parA5");
      check("par_spacing", pops[4] - pops[3], NB * C + 1);

      push(8'hA5);
      push(8'h3C);
      #1;
      check("rst_pop", {31'd0, ren}, 32'd1);
      @(posedge clk);
      repeat (17) @(negedge clk);
      check("rst_in_bit3", {busy, tx}, 2'b10);
      rst_n = 1'b0;
      hold  = 1'b1;
      @(negedge clk);
      check("rst_mid", {ren, tx, busy, frame_done}, 4'b0100);
      rst_n = 1'b1;
      hold  = 1'b0;
      #1;
      check("rst_repop", {31'd0, ren}, 32'd1);
      check_frame(8'h3C, "after_rst");
      check("rst_pops", pops.size(), 7);

      for (int i = 0; i < 20; i++) exp_bytes[i] = 8'((i * 37 + 11) % 256);
      for (int i = 0; i < 16; i++) push(exp_bytes[i]);
      next_wr = 16;
      #1;
      for (int j = 0; j < 20; j++) begin
         check_frame(exp_bytes[j], $sformatf("fifo%0d", j));
         if (next_wr < 20) begin
            push(exp_bytes[next_wr]);
            next_wr++;
         end
      end
      @(negedge clk);
      check("fifo_drained", {ren, empty}, 2'b01);
      check("ren_while_empty", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
